// File: rtl/flexdpe_ctrl.sv
// Job sequencer for flexdpe: takes one config, issues a stationary vector then N streaming rows,
// waits out the flexdpe pipeline and pulses done.
module flexdpe_ctrl #(
    parameter int unsigned IN_DATA_TYPE = 16,
    parameter int unsigned NUM_PES      = 32,
    parameter int unsigned LOG2_PES     = 5,
    parameter int unsigned ROWS_W       = 8,
    parameter int unsigned DRAIN_CYCLES = 8
) (
    input  logic                             CLK,
    input  logic                             rst,
    input  logic                             i_cfg_valid,
    output logic                             o_cfg_ready,
    input  logic [NUM_PES*LOG2_PES-1:0]      i_cfg_dest,
    input  logic [NUM_PES*LOG2_PES-1:0]      i_cfg_vn_sep,
    input  logic [ROWS_W-1:0]                i_cfg_num_rows,
    input  logic                             i_stat_valid,
    output logic                             o_stat_ready,
    input  logic [NUM_PES*IN_DATA_TYPE-1:0]  i_stat_data,
    input  logic                             i_strm_valid,
    output logic                             o_strm_ready,
    input  logic [NUM_PES*IN_DATA_TYPE-1:0]  i_strm_data,
    output logic                             o_dpe_data_valid,
    output logic                             o_dpe_stationary,
    output logic [NUM_PES*IN_DATA_TYPE-1:0]  o_dpe_data_bus,
    output logic [NUM_PES*LOG2_PES-1:0]      o_dpe_dest_bus,
    output logic [NUM_PES*LOG2_PES-1:0]      o_dpe_vn_seperator,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [ROWS_W-1:0]                o_rows_issued
);

    localparam int unsigned DataW  = NUM_PES * IN_DATA_TYPE;
    localparam int unsigned RouteW = NUM_PES * LOG2_PES;
    localparam int unsigned CntW   = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StStream, StDrain} state_e;

    state_e              state_q, state_d;
    logic [RouteW-1:0]   cfg_dest_q, cfg_dest_d;
    logic [RouteW-1:0]   cfg_vn_q, cfg_vn_d;
    logic [ROWS_W-1:0]   num_rows_q, num_rows_d;
    logic [ROWS_W-1:0]   rows_q, rows_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                stat_q, stat_d;
    logic [DataW-1:0]    data_q, data_d;
    logic [RouteW-1:0]   dest_q, dest_d;
    logic [RouteW-1:0]   vn_q, vn_d;
    logic                done_q, done_d;

    logic cfg_rdy, stat_rdy, strm_rdy;

    // Readies are pure state decodes, held low while reset is asserted.
    assign cfg_rdy  = rst && (state_q == StIdle);
    assign stat_rdy = rst && (state_q == StLoad);
    assign strm_rdy = rst && (state_q == StStream);

    always_comb begin
        state_d    = state_q;
        cfg_dest_d = cfg_dest_q;
        cfg_vn_d   = cfg_vn_q;
        num_rows_d = num_rows_q;
        rows_d     = rows_q;
        cnt_d      = cnt_q;
        valid_d    = 1'b0;
        stat_d     = 1'b0;
        data_d     = '0;
        dest_d     = '0;
        vn_d       = '0;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_cfg_valid && cfg_rdy) begin
                    cfg_dest_d = i_cfg_dest;
                    cfg_vn_d   = i_cfg_vn_sep;
                    num_rows_d = i_cfg_num_rows;
                    rows_d     = '0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                if (i_stat_valid && stat_rdy) begin
                    valid_d = 1'b1;
                    stat_d  = 1'b1;
                    data_d  = i_stat_data;
                    dest_d  = cfg_dest_q;
                    if (num_rows_q != '0) begin
                        state_d = StStream;
                    end else begin
                        state_d = StDrain;
                        cnt_d   = CntW'(DRAIN_CYCLES);
                    end
                end
            end
            StStream: begin
                if (i_strm_valid && strm_rdy) begin
                    valid_d = 1'b1;
                    data_d  = i_strm_data;
                    dest_d  = cfg_dest_q;
                    vn_d    = cfg_vn_q;
                    rows_d  = rows_q + ROWS_W'(1);
                    if ((rows_q + ROWS_W'(1)) == num_rows_q) begin
                        state_d = StDrain;
                        cnt_d   = CntW'(DRAIN_CYCLES);
                    end
                end
            end
            StDrain: begin
                // Counting down to zero places done DRAIN_CYCLES+1 cycles after the last beat.
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            state_q    <= StIdle;
            cfg_dest_q <= '0;
            cfg_vn_q   <= '0;
            num_rows_q <= '0;
            rows_q     <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            stat_q     <= 1'b0;
            data_q     <= '0;
            dest_q     <= '0;
            vn_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_dest_q <= cfg_dest_d;
            cfg_vn_q   <= cfg_vn_d;
            num_rows_q <= num_rows_d;
            rows_q     <= rows_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            stat_q     <= stat_d;
            data_q     <= data_d;
            dest_q     <= dest_d;
            vn_q       <= vn_d;
            done_q     <= done_d;
        end
    end

    assign o_cfg_ready        = cfg_rdy;
    assign o_stat_ready       = stat_rdy;
    assign o_strm_ready       = strm_rdy;
    assign o_dpe_data_valid   = valid_q;
    assign o_dpe_stationary   = stat_q;
    assign o_dpe_data_bus     = data_q;
    assign o_dpe_dest_bus     = dest_q;
    assign o_dpe_vn_seperator = vn_q;
    assign o_busy             = (state_q != StIdle);
    assign o_done             = done_q;
    assign o_rows_issued      = rows_q;

endmodule

// File: tb/tb_flexdpe_ctrl.sv
// Self-checking bench for flexdpe_ctrl: a negedge monitor keeps a queue of expected beats and a
// small job model; the driver runs the job scenarios.
module tb_flexdpe_ctrl;

    localparam int unsigned IN_DATA_TYPE = 16;
    localparam int unsigned NUM_PES      = 32;
    localparam int unsigned LOG2_PES     = 5;
    localparam int unsigned ROWS_W       = 8;
    localparam int unsigned DRAIN_CYCLES = 8;
    localparam int unsigned DataW        = NUM_PES * IN_DATA_TYPE;
    localparam int unsigned RouteW       = NUM_PES * LOG2_PES;

    typedef logic [DataW-1:0]  wide_t;
    typedef logic [RouteW-1:0] route_t;

    typedef struct {
        logic              stat;
        wide_t             data;
        route_t            dest;
        route_t            vn;
        logic [ROWS_W-1:0] rows;
        int unsigned       at;
    } beat_t;

    logic              CLK = 1'b0;
    logic              rst = 1'b0;
    logic              i_cfg_valid = 1'b0;
    logic              o_cfg_ready;
    route_t            i_cfg_dest = '0;
    route_t            i_cfg_vn_sep = '0;
    logic [ROWS_W-1:0] i_cfg_num_rows = '0;
    logic              i_stat_valid = 1'b0;
    logic              o_stat_ready;
    wide_t             i_stat_data = '0;
    logic              i_strm_valid = 1'b0;
    logic              o_strm_ready;
    wide_t             i_strm_data = '0;
    logic              o_dpe_data_valid;
    logic              o_dpe_stationary;
    wide_t             o_dpe_data_bus;
    route_t            o_dpe_dest_bus;
    route_t            o_dpe_vn_seperator;
    logic              o_busy;
    logic              o_done;
    logic [ROWS_W-1:0] o_rows_issued;

    flexdpe_ctrl #(
        .IN_DATA_TYPE(IN_DATA_TYPE),
        .NUM_PES     (NUM_PES),
        .LOG2_PES    (LOG2_PES),
        .ROWS_W      (ROWS_W),
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) u_dut (
        .CLK               (CLK),
        .rst               (rst),
        .i_cfg_valid       (i_cfg_valid),
        .o_cfg_ready       (o_cfg_ready),
        .i_cfg_dest        (i_cfg_dest),
        .i_cfg_vn_sep      (i_cfg_vn_sep),
        .i_cfg_num_rows    (i_cfg_num_rows),
        .i_stat_valid      (i_stat_valid),
        .o_stat_ready      (o_stat_ready),
        .i_stat_data       (i_stat_data),
        .i_strm_valid      (i_strm_valid),
        .o_strm_ready      (o_strm_ready),
        .i_strm_data       (i_strm_data),
        .o_dpe_data_valid  (o_dpe_data_valid),
        .o_dpe_stationary  (o_dpe_stationary),
        .o_dpe_data_bus    (o_dpe_data_bus),
        .o_dpe_dest_bus    (o_dpe_dest_bus),
        .o_dpe_vn_seperator(o_dpe_vn_seperator),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_rows_issued     (o_rows_issued)
    );

    always #5 CLK = ~CLK;

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check_eq(input string tag, input wide_t act, input wide_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic wide_t rnd_data();
        wide_t r;
        for (int i = 0; i < int'(DataW / 32); i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic route_t rnd_route();
        route_t r;
        for (int i = 0; i < int'(RouteW / 32); i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Monitor and job model
    beat_t             q[$];
    beat_t             e;
    int unsigned       ncyc = 0;
    int unsigned       rst_lo = 0;
    bit                seen_reset = 1'b0;
    bit                m_active = 1'b0;
    route_t            m_dest = '0;
    route_t            m_vn = '0;
    int unsigned       m_rows = 0;
    int unsigned       m_cnt = 0;
    int unsigned       exp_done_at = 0;
    logic              exp_busy;

    always @(negedge CLK) begin
        ncyc++;
        rst_lo = rst ? 0 : rst_lo + 1;
        if (rst_lo >= 2) seen_reset = 1'b1;
        if (seen_reset) begin
            exp_busy = m_active && (ncyc != exp_done_at);
            if (rst_lo >= 2) begin
                check_eq("rst_ctrl", wide_t'({o_dpe_data_valid, o_dpe_stationary, o_busy, o_done,
                         o_rows_issued, o_cfg_ready, o_stat_ready, o_strm_ready}), '0);
                check_eq("rst_data", o_dpe_data_bus, '0);
                check_eq("rst_route", wide_t'({o_dpe_dest_bus, o_dpe_vn_seperator}), '0);
            end else if (o_dpe_data_valid) begin
                if (q.size() == 0) begin
                    check_eq("beat_unexpected", wide_t'(o_dpe_data_valid), '0);
                end else begin
                    e = q.pop_front();
                    check_eq("beat_cycle", wide_t'(ncyc), wide_t'(e.at));
                    check_eq("beat_stationary", wide_t'(o_dpe_stationary), wide_t'(e.stat));
                    check_eq("beat_data", o_dpe_data_bus, e.data);
                    check_eq("beat_dest", wide_t'(o_dpe_dest_bus), wide_t'(e.dest));
                    check_eq("beat_vn", wide_t'(o_dpe_vn_seperator), wide_t'(e.vn));
                    check_eq("beat_rows_issued", wide_t'(o_rows_issued), wide_t'(e.rows));
                end
            end else begin
                check_eq("idle_ctrl_route", wide_t'({o_dpe_stationary, o_dpe_dest_bus,
                         o_dpe_vn_seperator}), '0);
                check_eq("idle_data", o_dpe_data_bus, '0);
            end
            if (rst) begin
                check_eq("busy", wide_t'(o_busy), wide_t'(exp_busy));
                check_eq("cfg_ready", wide_t'(o_cfg_ready), wide_t'(!exp_busy));
            end
            check_eq("strm_ready_excess", wide_t'(o_strm_ready && (m_cnt >= m_rows)), '0);
            if (o_done || (exp_done_at != 0 && ncyc == exp_done_at)) begin
                check_eq("done_cycle", wide_t'(o_done), wide_t'(ncyc == exp_done_at));
                if (o_done) check_eq("done_rows_issued", wide_t'(o_rows_issued), wide_t'(m_rows));
            end
        end
        if (!rst) begin
            m_active    = 1'b0;
            exp_done_at = 0;
            m_cnt       = 0;
            m_rows      = 0;
        end else begin
            if (ncyc == exp_done_at) m_active = 1'b0;
            if (i_cfg_valid && o_cfg_ready) begin
                m_active = 1'b1;
                m_dest   = i_cfg_dest;
                m_vn     = i_cfg_vn_sep;
                m_rows   = i_cfg_num_rows;
                m_cnt    = 0;
            end
            if (i_stat_valid && o_stat_ready) begin
                q.push_back('{stat: 1'b1, data: i_stat_data, dest: m_dest, vn: '0,
                              rows: '0, at: ncyc + 1});
                if (m_rows == 0) exp_done_at = ncyc + 2 + DRAIN_CYCLES;
            end
            if (i_strm_valid && o_strm_ready) begin
                m_cnt++;
                q.push_back('{stat: 1'b0, data: i_strm_data, dest: m_dest, vn: m_vn,
                              rows: m_cnt[ROWS_W-1:0], at: ncyc + 1});
                if (m_cnt == m_rows) exp_done_at = ncyc + 2 + DRAIN_CYCLES;
            end
        end
    end

    // Driver
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic await_ready(input int which, output int waited);
        logic r;
        r = 1'b0;
        waited = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge CLK);
            r = (which == 0) ? o_cfg_ready : (which == 1) ? o_stat_ready : o_strm_ready;
            if (r) begin
                waited = i;
                break;
            end
        end
        if (waited == 0) check_eq("ready_timeout", wide_t'(r), wide_t'(1));
        tick();
    endtask

    task automatic wait_done();
        logic d;
        bit   got;
        d = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            d = o_done;
            if (d) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check_eq("done_timeout", wide_t'(d), wide_t'(1));
        tick();
    endtask

    task automatic send_cfg(input int rows);
        int w;
        i_cfg_valid    = 1'b1;
        i_cfg_num_rows = rows[ROWS_W-1:0];
        i_cfg_dest     = rnd_route();
        i_cfg_vn_sep   = rnd_route();
        await_ready(0, w);
        i_cfg_valid = 1'b0;
    endtask

    task automatic send_stat(input wide_t d);
        int w;
        i_stat_valid = 1'b1;
        i_stat_data  = d;
        await_ready(1, w);
        i_stat_valid = 1'b0;
    endtask

    task automatic send_row(input int gap);
        int w;
        i_strm_valid = 1'b0;
        repeat (gap) tick();
        i_strm_valid = 1'b1;
        i_strm_data  = rnd_data();
        await_ready(2, w);
    endtask

    task automatic run_job(input int rows, input bit gappy, input wide_t stat);
        send_cfg(rows);
        send_stat(stat);
        for (int r = 0; r < rows; r++) send_row((gappy && (r == 1 || r == 2)) ? 1 : 0);
        i_strm_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        int w;
        wide_t ones;
        ones = {NUM_PES{16'h3F80}};
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        run_job(5, 1'b0, ones);
        run_job(4, 1'b1, rnd_data());
        run_job(0, 1'b0, rnd_data());

        // Config valid held across a job; next job taken on the done cycle.
        i_cfg_valid    = 1'b1;
        i_cfg_num_rows = 8'd2;
        i_cfg_dest     = rnd_route();
        i_cfg_vn_sep   = rnd_route();
        i_stat_valid   = 1'b1;
        i_stat_data    = rnd_data();
        await_ready(0, w);
        i_cfg_num_rows = 8'd1;
        i_cfg_dest     = rnd_route();
        i_cfg_vn_sep   = rnd_route();
        await_ready(1, w);
        i_stat_data = rnd_data();
        send_row(0);
        send_row(0);
        i_strm_valid = 1'b0;
        wait_done();
        i_cfg_valid = 1'b0;
        await_ready(1, w);
        check_eq("stat_no_bubble", wide_t'(w), wide_t'(1));
        i_stat_valid = 1'b0;
        send_row(0);
        i_strm_valid = 1'b0;
        wait_done();

        // Reset in the middle of a job, then a fresh job.
        send_cfg(5);
        send_stat(rnd_data());
        send_row(0);
        send_row(0);
        rst = 1'b0;
        i_strm_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        run_job(3, 1'b0, rnd_data());

        run_job(255, 1'b0, rnd_data());
        repeat (3) tick();

        check_eq("queue_drained", wide_t'(q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
